// File: rtl/spi_pkg.sv
// Shared SPI frame constants and opcode set.
// Used by the frame shifter, controller_bos and the benches.
package spi_pkg;

  localparam int FRAME_W = 136;
  localparam int CODE_W  = 8;
  localparam int CNT_W   = 8;

  typedef enum logic [CODE_W-1:0] {
    IDLE     = 8'd0,
    STIM_DD  = 8'd1,
    STIM_XOR = 8'd2,
    READ_DD  = 8'd3,
    READ_XOR = 8'd4
  } opcode_t;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  function automatic logic [CODE_W-1:0] opcode_of(
    input logic [FRAME_W-1:0] word
  );
    return word[FRAME_W-1 -: CODE_W];
  endfunction

endpackage

// File: rtl/spi_frame_shifter_if.sv
// SPI pad bundle between an external master and the frame shifter.
// Signal names follow the chip pads.
interface spi_frame_shifter_if;

  logic SCLK;
  logic CS_N;
  logic MOSI;
  logic MISO;

  modport master (
    output SCLK,
    output CS_N,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SCLK,
    input  CS_N,
    input  MOSI,
    output MISO
  );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop pin synchroniser with rise/fall detection
// on the synchronised level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Resets low so a pin already low at release never
  // looks like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_frame_shifter.sv
// SPI mode-0 slave: oversampled 136-bit frame deserialiser
// with simultaneous MISO serialisation of TO_SEND.
module spi_frame_shifter #(
  parameter int FRAME_W     = 136,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  spi_frame_shifter_if.slave spi,
  input  logic [FRAME_W-1:0] TO_SEND,
  output logic [FRAME_W-1:0] RECEIVED,
  output logic               RX_VALID,
  output logic               RX_ERR,
  output logic               BUSY
);

  import spi_pkg::*;

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk   (CLK),
    .rst_n (RESET),
    .d     (spi.SCLK),
    .q     (sck_s),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk   (CLK),
    .rst_n (RESET),
    .d     (spi.CS_N),
    .q     (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk   (CLK),
    .rst_n (RESET),
    .d     (spi.MOSI),
    .q     (mosi_s),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  assign unused_edges = ^{sck_s, mosi_rise, mosi_fall};

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] rx_shift;
  logic [FRAME_W-1:0] tx_shift;
  logic               armed;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      RECEIVED <= '0;
      RX_VALID <= 1'b0;
      RX_ERR   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      RX_VALID <= 1'b0;
      RX_ERR   <= 1'b0;
      if (cs_s) armed <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (cs_fall) begin
            tx_shift <= TO_SEND;
            rx_shift <= '0;
            bit_cnt  <= '0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // End of frame beats any SCLK edge seen together.
          if (cs_rise) begin
            state <= S_IDLE;
            if (bit_cnt == CNT_W'(FRAME_W)) begin
              RECEIVED <= rx_shift;
              RX_VALID <= 1'b1;
            end else begin
              RX_ERR <= 1'b1;
            end
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[FRAME_W-2:0], mosi_s};
            if (bit_cnt != {CNT_W{1'b1}})
              bit_cnt <= bit_cnt + 1'b1;
          end else if (sck_fall) begin
            tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign spi.MISO = tx_shift[FRAME_W-1];
  assign BUSY     = armed & ~cs_s;

endmodule
